// File: rtl/chip8_scanout_if.sv
// VRAM read port between chip8_scanout (master) and the CHIP-8 framebuffer RAM (slave).
// The pixel is returned one clk after the address is presented.
interface chip8_scanout_if;
    logic [6:0] vram_rd_hpos;
    logic [5:0] vram_rd_vpos;
    logic [1:0] vram_rd_pixel;

    modport master (
        output vram_rd_hpos,
        output vram_rd_vpos,
        input  vram_rd_pixel
    );

    modport slave (
        input  vram_rd_hpos,
        input  vram_rd_vpos,
        output vram_rd_pixel
    );
endinterface

// File: rtl/chip8_scanout.sv
// 640x480@60 VGA scanout of the CHIP-8 framebuffer, scaled into a 512x256 centred window.
// Optional macro SCANOUT_BORDER_EN paints the visible border with BORDER_RGB instead of black.
module chip8_scanout #(
    parameter logic [11:0] FG_RGB = 12'hFFF,
    parameter logic [11:0] BG_RGB = 12'h000
`ifdef SCANOUT_BORDER_EN
    ,
    parameter logic [11:0] BORDER_RGB = 12'h00F
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hires,
    chip8_scanout_if.master        vram,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   active,
    output logic [11:0]            rgb
);

    localparam logic [9:0] H_LAST    = 10'd799;
    localparam logic [9:0] V_LAST    = 10'd524;
    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] HS_FIRST  = 10'd656;
    localparam logic [9:0] HS_LAST   = 10'd751;
    localparam logic [9:0] VS_FIRST  = 10'd490;
    localparam logic [9:0] VS_LAST   = 10'd491;
    localparam logic [9:0] WIN_X0    = 10'd64;
    localparam logic [9:0] WIN_X1    = 10'd575;
    localparam logic [9:0] WIN_Y0    = 10'd112;
    localparam logic [9:0] WIN_Y1    = 10'd367;
    localparam logic [9:0] MODE_LINE = 10'd480;

    // Half-intensity colour for the two intermediate SCHIP plane values.
    localparam logic [4:0] MID_R = ({1'b0, FG_RGB[11:8]} + {1'b0, BG_RGB[11:8]}) >> 1;
    localparam logic [4:0] MID_G = ({1'b0, FG_RGB[7:4]}  + {1'b0, BG_RGB[7:4]})  >> 1;
    localparam logic [4:0] MID_B = ({1'b0, FG_RGB[3:0]}  + {1'b0, BG_RGB[3:0]})  >> 1;
    localparam logic [11:0] MID_RGB = {MID_R[3:0], MID_G[3:0], MID_B[3:0]};

`ifdef SCANOUT_BORDER_EN
    localparam logic [11:0] BORDER_COLOUR = BORDER_RGB;
`else
    localparam logic [11:0] BORDER_COLOUR = 12'h000;
`endif

    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic        mode_q;
    logic [9:0]  hx;
    logic [9:0]  vy;
    logic        vis_0;
    logic        hs_0;
    logic        vs_0;
    logic        win_0;
    logic        win_1;
    logic        act_1;
    logic        hs_1;
    logic        vs_1;
    logic [11:0] pix_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    // Mode is sampled once per frame in vertical blanking so a frame never mixes resolutions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else if (hcnt == 10'd0 && vcnt == MODE_LINE) begin
            mode_q <= hires;
        end
    end

    always_comb begin
        vis_0 = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE);
        hs_0  = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
        vs_0  = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
        win_0 = (hcnt >= WIN_X0) && (hcnt <= WIN_X1) &&
                (vcnt >= WIN_Y0) && (vcnt <= WIN_Y1);
        hx    = hcnt - WIN_X0;
        vy    = vcnt - WIN_Y0;
    end

    // Each VRAM pixel covers 4x4 screen pixels in hires and 8x8 in lores.
    always_comb begin
        vram.vram_rd_hpos = '0;
        vram.vram_rd_vpos = '0;
        if (win_0) begin
            if (mode_q) begin
                vram.vram_rd_hpos = 7'(hx >> 2);
                vram.vram_rd_vpos = 6'(vy >> 2);
            end else begin
                vram.vram_rd_hpos = 7'(hx >> 3);
                vram.vram_rd_vpos = 6'(vy >> 3);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_1 <= 1'b0;
            act_1 <= 1'b0;
            hs_1  <= 1'b0;
            vs_1  <= 1'b0;
        end else begin
            win_1 <= win_0;
            act_1 <= vis_0;
            hs_1  <= hs_0;
            vs_1  <= vs_0;
        end
    end

    always_comb begin
        pix_rgb = BORDER_COLOUR;
        if (win_1) begin
            case (vram.vram_rd_pixel)
                2'd0:    pix_rgb = BG_RGB;
                2'd3:    pix_rgb = FG_RGB;
                default: pix_rgb = MID_RGB;
            endcase
        end
    end

    // Syncs and active are re-registered here so they stay aligned with rgb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            rgb    <= '0;
        end else begin
            active <= act_1;
            hsync  <= hs_1;
            vsync  <= vs_1;
            rgb    <= act_1 ? pix_rgb : 12'h000;
        end
    end

endmodule

// File: tb/tb_chip8_scanout.sv
// Bench for chip8_scanout: VRAM model, frame-position reference model, vector table and corner sequences.
// Long blanking stretches are skipped by loading the raster counters directly.
module tb_chip8_scanout;

    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;
`ifdef SCANOUT_BORDER_EN
    localparam logic [11:0] BRD = 12'h00F;
`else
    localparam logic [11:0] BRD = 12'h000;
`endif

    typedef struct packed {
        logic        act;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    typedef struct {
        int          h;
        int          v;
        logic        hr;
        logic        act;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hires = 1'b0;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic [11:0] rgb;

    logic [1:0]  vram [0:63][0:127];
    exp_t        s1;
    exp_t        s2;
    int          mh;
    int          mv;
    logic        mmode;
    logic [9:0]  force_h;
    logic [9:0]  force_v;
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        vecs [$];

    chip8_scanout_if vif ();

    chip8_scanout #(
        .FG_RGB (FG),
        .BG_RGB (BG)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .hires  (hires),
        .vram   (vif),
        .hsync  (hsync),
        .vsync  (vsync),
        .active (active),
        .rgb    (rgb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) vif.vram_rd_pixel <= vram[vif.vram_rd_vpos][vif.vram_rd_hpos];

    function automatic logic in_window(int h, int v);
        return (h >= 64) && (h <= 575) && (v >= 112) && (v <= 367);
    endfunction

    function automatic logic [11:0] mid_rgb();
        int f = FG;
        int b = BG;
        int r = (((f >> 8) & 15) + ((b >> 8) & 15)) / 2;
        int g = (((f >> 4) & 15) + ((b >> 4) & 15)) / 2;
        int u = ((f & 15) + (b & 15)) / 2;
        return 12'(r * 256 + g * 16 + u);
    endfunction

    // Expected outputs for a raster position, straight from the VGA timing and window rules.
    function automatic exp_t model_out(int h, int v, logic mode);
        exp_t e;
        int   div;
        logic [1:0] px;
        e.act = (h < 640) && (v < 480);
        e.hs  = (h >= 656) && (h <= 751);
        e.vs  = (v == 490) || (v == 491);
        e.rgb = 12'h000;
        if (e.act) begin
            if (in_window(h, v)) begin
                div = mode ? 4 : 8;
                px  = vram[(v - 112) / div][(h - 64) / div];
                e.rgb = (px == 2'd0) ? BG : (px == 2'd3) ? FG : mid_rgb();
            end else begin
                e.rgb = BRD;
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (model h=%0d v=%0d, t=%0t)",
                     name, got, expv, mh, mv, $time);
        end
    endtask

    task automatic advance();
        int   ph = mh;
        int   pv = mv;
        logic phires = hires;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            s1 = '0;
            s2 = '0;
            mh = 0;
            mv = 0;
            mmode = 1'b0;
        end else begin
            s2 = s1;
            s1 = model_out(ph, pv, mmode);
            if (ph == 0 && pv == 480) mmode = phires;
            mh = ph + 1;
            mv = pv;
            if (mh == 800) begin
                mh = 0;
                mv = (pv == 524) ? 0 : pv + 1;
            end
        end
    endtask

    task automatic check_cycle();
        int eh = 0;
        int ev = 0;
        checkOutput("active", active, s2.act);
        checkOutput("hsync", hsync, s2.hs);
        checkOutput("vsync", vsync, s2.vs);
        checkOutput("rgb", rgb, s2.rgb);
        if (rst_n && in_window(mh, mv)) begin
            eh = (mh - 64) / (mmode ? 4 : 8);
            ev = (mv - 112) / (mmode ? 4 : 8);
        end
        checkOutput("vram_hpos", vif.vram_rd_hpos, eh);
        checkOutput("vram_vpos", vif.vram_rd_vpos, ev);
    endtask

    task automatic tick();
        advance();
        check_cycle();
    endtask

    // Load the raster counters so that the next clock edge sees position (h, v).
    task automatic jump_to(input int h, input int v);
        @(negedge clk);
        force_h = 10'(h);
        force_v = 10'(v);
        force dut.hcnt = force_h;
        force dut.vcnt = force_v;
        mh = h;
        mv = v;
        advance();
        force_h = 10'(mh);
        force_v = 10'(mv);
        force dut.hcnt = force_h;
        force dut.vcnt = force_v;
        release dut.hcnt;
        release dut.vcnt;
        #1;
        check_cycle();
    endtask

    task automatic add_vec(input int h, input int v, input logic hr, input logic act,
                           input logic hs, input logic vs, input logic [11:0] c);
        vec_t t;
        t.h = h; t.v = v; t.hr = hr; t.act = act; t.hs = hs; t.vs = vs; t.rgb = c;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input int idx, input vec_t t);
        if (t.hr != mmode) begin
            hires = t.hr;
            jump_to(0, 480);
        end
        jump_to(t.h, t.v);
        tick();
        checkOutput($sformatf("vec%0d_active", idx), active, t.act);
        checkOutput($sformatf("vec%0d_hsync", idx), hsync, t.hs);
        checkOutput($sformatf("vec%0d_vsync", idx), vsync, t.vs);
        checkOutput($sformatf("vec%0d_rgb", idx), rgb, t.rgb);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no $finish, expected end of test before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   pulses;
        int   width;
        int   rises;
        logic prev;
        logic found;

        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++)
                vram[r][c] = 2'd0;
        s1 = '0;
        s2 = '0;
        mh = 0;
        mv = 0;
        mmode = 1'b0;

        #1;
        checkOutput("reset_active", active, 0);
        checkOutput("reset_hsync", hsync, 0);
        checkOutput("reset_vsync", vsync, 0);
        checkOutput("reset_rgb", rgb, 0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick();

        vram[0][0]    = 2'd3;
        vram[31][63]  = 2'd3;
        vram[1][2]    = 2'd1;
        vram[63][127] = 2'd1;

        add_vec(0,   0,   0, 1, 0, 0, BRD);
        add_vec(64,  112, 0, 1, 0, 0, 12'hFFF);
        add_vec(71,  119, 0, 1, 0, 0, 12'hFFF);
        add_vec(72,  112, 0, 1, 0, 0, 12'h000);
        add_vec(80,  120, 0, 1, 0, 0, 12'h777);
        add_vec(568, 360, 0, 1, 0, 0, 12'hFFF);
        add_vec(575, 367, 0, 1, 0, 0, 12'hFFF);
        add_vec(572, 364, 0, 1, 0, 0, 12'hFFF);
        add_vec(576, 367, 0, 1, 0, 0, BRD);
        add_vec(63,  200, 0, 1, 0, 0, BRD);
        add_vec(200, 111, 0, 1, 0, 0, BRD);
        add_vec(200, 368, 0, 1, 0, 0, BRD);
        add_vec(639, 479, 0, 1, 0, 0, BRD);
        add_vec(640, 100, 0, 0, 0, 0, 12'h000);
        add_vec(655, 100, 0, 0, 0, 0, 12'h000);
        add_vec(656, 100, 0, 0, 1, 0, 12'h000);
        add_vec(751, 100, 0, 0, 1, 0, 12'h000);
        add_vec(752, 100, 0, 0, 0, 0, 12'h000);
        add_vec(100, 489, 0, 0, 0, 0, 12'h000);
        add_vec(100, 490, 0, 0, 0, 1, 12'h000);
        add_vec(799, 491, 0, 0, 0, 1, 12'h000);
        add_vec(100, 492, 0, 0, 0, 0, 12'h000);
        add_vec(700, 490, 0, 0, 1, 1, 12'h000);
        add_vec(64,  112, 1, 1, 0, 0, 12'hFFF);
        add_vec(67,  115, 1, 1, 0, 0, 12'hFFF);
        add_vec(68,  112, 1, 1, 0, 0, 12'h000);
        add_vec(64,  116, 1, 1, 0, 0, 12'h000);
        add_vec(71,  119, 1, 1, 0, 0, 12'h000);
        add_vec(572, 364, 1, 1, 0, 0, 12'h777);
        add_vec(568, 360, 1, 1, 0, 0, 12'h000);
        add_vec(80,  120, 0, 1, 0, 0, 12'h777);
        foreach (vecs[i]) applyStimulus(i, vecs[i]);

        // Mode change mid-frame must wait for the line-480 latch.
        hires = 1'b0;
        jump_to(0, 480);
        jump_to(0, 200);
        hires = 1'b1;
        repeat (10) tick();
        jump_to(572, 364);
        tick();
        checkOutput("toggle_hold_rgb", rgb, 12'hFFF);
        jump_to(795, 479);
        repeat (10) tick();
        jump_to(572, 364);
        tick();
        checkOutput("toggle_next_rgb", rgb, 12'h777);
        hires = 1'b0;
        jump_to(798, 479);
        repeat (10) tick();

        jump_to(600, 100);
        pulses = 0;
        width = 0;
        prev = hsync;
        for (int i = 0; i < 1650; i++) begin
            tick();
            if (hsync) width++;
            if (prev && !hsync) begin
                pulses++;
                checkOutput("hsync_width", width, 96);
                width = 0;
            end
            prev = hsync;
        end
        checkOutput("hsync_pulses", pulses, 2);

        jump_to(0, 486);
        rises = 0;
        width = 0;
        prev = vsync;
        for (int i = 0; i < 5600; i++) begin
            tick();
            if (vsync) width++;
            if (!prev && vsync) begin
                rises++;
                checkOutput("vsync_rise_v", mv, 490);
                checkOutput("vsync_rise_h", mh, 2);
            end
            prev = vsync;
        end
        checkOutput("vsync_pulses", rises, 1);
        checkOutput("vsync_width", width, 1600);

        // Reset in the middle of a vsync pulse.
        jump_to(690, 490);
        for (int k = 0; k < 20 && mh != 700; k++) tick();
        checkOutput("pre_reset_vsync", vsync, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_vsync", vsync, 0);
        checkOutput("rst_hsync", hsync, 0);
        checkOutput("rst_active", active, 0);
        checkOutput("rst_rgb", rgb, 0);
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (vsync) rises++;
        end
        checkOutput("no_partial_vsync", rises, 0);
        jump_to(790, 489);
        found = 1'b0;
        prev = vsync;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick();
            if (!prev && vsync) begin
                found = 1'b1;
                checkOutput("post_reset_rise_v", mv, 490);
                checkOutput("post_reset_rise_h", mh, 2);
            end
            prev = vsync;
        end
        checkOutput("post_reset_vsync_seen", found, 1);

        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++)
                vram[r][c] = 2'($urandom_range(0, 3));
        for (int it = 0; it < 40; it++) begin
            int h;
            int v;
            hires = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) jump_to(0, 480);
            h = int'($urandom_range(0, 799));
            v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(100, 380))
                                             : int'($urandom_range(0, 524));
            jump_to(h, v);
            repeat (40) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chip8_scanout.md
CHIP8_SCANOUT -- requirements
Module: chip8_scanout

Interface
REQ-001 SHALL use one clock and one reset: clock is clk; reset is rst_n, asynchronous and active-low.
REQ-002 SHALL expose the ports below. Sync outputs are active-high.
- clk  in  1  pixel clock, 25.175 MHz nominal
- rst_n  in  1  async active-low reset
- hires  in  1  CPU display mode: 1 = 128x64, 0 = 64x32
- vram_rd_hpos  out  7  VRAM read column
- vram_rd_vpos  out  6  VRAM read row
- vram_rd_pixel  in  2  VRAM read data, valid one clk after address
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync; its rising edge is the CPU 60 Hz timer tick
- active  out  1  visible-area flag
- rgb  out  12  pixel colour, {r[3:0], g[3:0], b[3:0]}
REQ-003 SHALL provide parameters FG_RGB (default 12'hFFF) and BG_RGB (default 12'h000).

Function
REQ-004 SHALL keep hcnt 0..799 and vcnt 0..524.
- hcnt increments every clk and wraps 799->0.
- vcnt increments on the hcnt wrap and wraps 524->0.
REQ-005 SHALL decode timing from the stage-0 counters:
- visible area: hcnt<640 && vcnt<480
- hsync: hcnt 656..751
- vsync: vcnt 490..491
REQ-006 SHALL define the picture window as hcnt 64..575 and vcnt 112..367 (512x256); everything else visible is border.
REQ-007 SHALL drive the VRAM address combinationally from the stage-0 counters using the latched mode:
- hires: hpos=(hcnt-64)>>2, vpos=(vcnt-112)>>2
- lores: hpos=(hcnt-64)>>3, vpos=(vcnt-112)>>3; this covers VRAM columns 0..63 and rows 0..31
- outside the window: hpos=0, vpos=0
REQ-008 SHALL latch hires into mode_q only at hcnt==0 && vcnt==480, so the mode is constant for a whole frame.
REQ-009 SHALL implement a 2-stage pipeline:
- stage 1 registers the window flag, active, hsync and vsync alongside the VRAM read;
- stage 2 registers rgb, and also registers active, hsync and vsync.
- Total latency from counters to all outputs is 2 clk, and the outputs stay mutually aligned.
REQ-010 SHALL map vram_rd_pixel to rgb inside the window:
- 0 -> BG_RGB
- 3 -> FG_RGB
- 1 or 2 -> per-channel average (FG+BG)>>1, computed in 5-bit intermediates
REQ-011 SHALL force rgb=0 when active is 0.
REQ-012 SHALL drive rgb in border regions as defined in REQ-018.
REQ-013 SHALL treat VRAM as read-only and never drive a write enable. CPU writes during scanout are allowed, and tearing is acceptable.

Reset
REQ-014 SHALL asynchronously clear, on rst_n low: hcnt, vcnt, mode_q, all pipeline registers, hsync, vsync, active, rgb.
REQ-015 SHALL start from hcnt=0, vcnt=0 on the first clk after rst_n deasserts, with mode_q=0 (lores) until the first latch point.
REQ-016 SHALL, on reset mid-line or mid-vsync, drop vsync/hsync within the reset assertion with no partial pulse afterward.

Configuration
REQ-017 SHALL use macro SCANOUT_BORDER_EN.
REQ-018 SHALL drive border rgb as follows:
- SCANOUT_BORDER_EN defined: visible border = parameter BORDER_RGB (default 12'h00F).
- Undefined: border rgb=0, and BORDER_RGB is unused.

Verification
REQ-019 SHALL cover these directed scenarios:
- Reset release, count 800*525 clk -> exactly one 2-line vsync pulse at vcnt 490..491; 525 hsync pulses, each 96 clk wide.
- hires=1, VRAM(0,0)=3 and all other locations 0 -> rgb=FG_RGB at hcnt 64..67 of lines 112..115 (outputs observed 2 clk later); BG_RGB elsewhere in the window.
- hires=0, VRAM(63,31)=3 -> FG_RGB on hcnt 568..575, vcnt 360..367; VRAM columns 64..127 are never addressed.
- hires toggled at vcnt=200 -> output mode unchanged until the frame after the vcnt=480 latch.
- VRAM pixel value 1 with FG=12'hFFF, BG=12'h000 -> rgb=12'h777.
- rst_n pulsed low at hcnt=700, vcnt=490 -> vsync=0 immediately; the next vsync rises at vcnt=490 of the following frame, with SCANOUT_BORDER_EN both defined (border 12'h00F) and undefined (border 0).
